// File: rtl/alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer
//
// Shares one single-cycle ALU between the execute stage and an iterative
// shift-add multiplier that produces the low WIDTH bits of a RISC-V MUL.
// When no multiply is running, the pipeline's ALU request is forwarded
// unchanged. While a multiply runs, the sequencer owns the ALU, issues one
// ADD per cycle and stalls the pipeline.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   start                   multiply request, accepted in IDLE or DONE
//   operand_a, operand_b    multiplicand / multiplier, latched on accept
//   busy, stall             high while the multiply loop is running
//   done                    one-cycle pulse when result becomes valid
//   result                  low WIDTH bits of the product, held until the
//                           next accepted multiply completes
//   cpu_operation/in_x/in_y ALU request from the pipeline
//   alu_operation/in_x/in_y request driven to the shared ALU
//   alu_out_s               shared ALU result
// ---------------------------------------------------------------------------
module alu_mul_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result,
   input  logic [3:0]       cpu_operation,
   input  logic [WIDTH-1:0] cpu_in_x,
   input  logic [WIDTH-1:0] cpu_in_y,
   output logic [3:0]       alu_operation,
   output logic [WIDTH-1:0] alu_in_x,
   output logic [WIDTH-1:0] alu_in_y,
   input  logic [WIDTH-1:0] alu_out_s
);

   localparam int          CW      = $clog2(WIDTH);
   localparam logic [3:0]  OP_ADD  = 4'b0010;

   typedef logic [CW-1:0] count_t;
   localparam count_t LAST_COUNT = count_t'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e           state_q,  state_d;
   logic [WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q,    acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   count_t           count_q,  count_d;

   logic             accept;
   logic             run_last;

   // A new multiply may only be taken when the loop is not running.
   // The loop ends as soon as the remaining multiplier bits are all zero,
   // so small multipliers finish early; the count bound guarantees the
   // loop never exceeds WIDTH iterations even if the early exit misfires.
   always_comb begin
      accept   = start && (state_q != RUN);
      run_last = ((mplier_q >> 1) == '0) || (count_q == LAST_COUNT);
   end

   // State and datapath registers. Reset wins over everything, so a reset
   // in the middle of a multiply drops it without a done pulse and clears
   // the visible result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         result_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         count_q  <= count_d;
      end
   end

   // Next-state logic. DONE goes straight back to RUN when a new request
   // is already waiting, so back-to-back multiplies need no IDLE gap.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (run_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = start ? RUN : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Shift-add datapath. Each RUN cycle the shared ALU adds either the
   // shifted multiplicand or zero into the accumulator; the multiplicand
   // moves left and the multiplier right so bit 0 always selects the next
   // partial product. The final ALU sum is captured straight into result
   // so the product is visible in the DONE cycle.
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      result_d = result_q;
      count_d  = count_q;
      if (accept) begin
         mcand_d  = operand_a;
         mplier_d = operand_b;
         acc_d    = '0;
         count_d  = '0;
      end else if (state_q == RUN) begin
         acc_d    = alu_out_s;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         count_d  = count_q + count_t'(1);
         if (run_last) begin
            result_d = alu_out_s;
         end
      end
   end

   // Output logic. Outside RUN the pipeline's request passes through
   // untouched, including in the DONE cycle, so the pipeline regains the
   // ALU at the same time the product is announced.
   always_comb begin
      busy          = (state_q == RUN);
      stall         = (state_q == RUN);
      done          = (state_q == DONE);
      result        = result_q;
      alu_operation = cpu_operation;
      alu_in_x      = cpu_in_x;
      alu_in_y      = cpu_in_y;
      if (state_q == RUN) begin
         alu_operation = OP_ADD;
         alu_in_x      = acc_q;
         alu_in_y      = mplier_q[0] ? mcand_q : '0;
      end
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_sequencer
//
// Scoreboard bench for the shared-ALU multiply sequencer. A behavioural ALU
// answers the sequencer's requests. The driver decides from a plain
// timing/arithmetic model whether each start is accepted and, if so, pushes
// the product and its expected busy window and done cycle into a queue.
// A monitor on the falling edge pops the queue whenever done appears and
// also checks busy/stall, ALU ownership and result holding every cycle.
// ---------------------------------------------------------------------------
module tb_alu_mul_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] result;
   logic [3:0]  cpu_operation;
   logic [31:0] cpu_in_x;
   logic [31:0] cpu_in_y;
   logic [3:0]  alu_operation;
   logic [31:0] alu_in_x;
   logic [31:0] alu_in_y;
   logic [31:0] alu_out_s;

   typedef struct {
      logic [31:0] product;
      int          run_first;
      int          done_cycle;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] held_result;
   int          cyc;
   int          n_checks;
   int          n_pass;
   logic        mon_en;

   alu_mul_sequencer #(.WIDTH(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .busy          (busy),
      .stall         (stall),
      .done          (done),
      .result        (result),
      .cpu_operation (cpu_operation),
      .cpu_in_x      (cpu_in_x),
      .cpu_in_y      (cpu_in_y),
      .alu_operation (alu_operation),
      .alu_in_x      (alu_in_x),
      .alu_in_y      (alu_in_y),
      .alu_out_s     (alu_out_s)
   );

   // Behavioural stand-in for the single-cycle ALU the sequencer drives.
   function automatic logic [31:0] aluModel(input logic [3:0] op,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
      case (op)
         4'b0000: return x & y;
         4'b0001: return x | y;
         4'b0010: return x + y;
         4'b0110: return x - y;
         default: return 32'd0;
      endcase
   endfunction

   assign alu_out_s = aluModel(alu_operation, alu_in_x, alu_in_y);

   // Free-running clock and an absolute cycle counter used by the model.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Index of the highest set bit of the multiplier, zero for zero.
   function automatic int msbIndex(input logic [31:0] b);
      int h;
      h = 0;
      for (int i = 0; i < 32; i++) begin
         if (b[i]) h = i;
      end
      return h;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h",
                  name, cyc, actual, expected);
      end
   endtask

   // Advance one clock and drive fresh pipeline ALU requests that are never
   // an ADD, so any forwarding during RUN is visible.
   task automatic tick();
      logic [3:0] ops [4];
      ops[0] = 4'b0000;
      ops[1] = 4'b0001;
      ops[2] = 4'b0110;
      ops[3] = 4'b0111;
      @(posedge clk);
      #1;
      cpu_operation = ops[$urandom_range(0, 3)];
      cpu_in_x      = $urandom;
      cpu_in_y      = $urandom;
   endtask

   // Pulse start for one cycle. The request is accepted unless a multiply
   // is still short of its done cycle; accepted requests are scoreboarded.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      bit   accepted;
      start     = 1'b1;
      operand_a = a;
      operand_b = b;
      accepted  = 1'b1;
      if (sb_q.size() != 0) begin
         if (cyc < sb_q[$].done_cycle) accepted = 1'b0;
      end
      if (accepted) begin
         e.product    = a * b;
         e.run_first  = cyc + 1;
         e.done_cycle = cyc + msbIndex(b) + 2;
         sb_q.push_back(e);
      end
      tick();
      start     = 1'b0;
      operand_a = $urandom;
      operand_b = $urandom;
   endtask

   // Let outstanding multiplies finish, bounded so a stuck DUT still ends.
   task automatic waitIdle();
      for (int i = 0; i < 80 && sb_q.size() != 0; i++) tick();
      tick();
      checkOutput("drain", sb_q.size(), 0);
   endtask

   // Monitor: pops the scoreboard on done and checks per-cycle behaviour.
   always @(negedge clk) begin
      if (mon_en) begin
         bit   exp_busy;
         exp_t e;
         exp_busy = 1'b0;
         if (sb_q.size() != 0) begin
            exp_busy = (cyc >= sb_q[0].run_first) && (cyc < sb_q[0].done_cycle);
         end
         if (done) begin
            if (sb_q.size() == 0) begin
               checkOutput("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
               e = sb_q.pop_front();
               checkOutput("done_cycle", cyc, e.done_cycle);
               checkOutput("product", result, e.product);
               held_result = e.product;
            end
         end else if (sb_q.size() != 0) begin
            if (cyc >= sb_q[0].done_cycle) begin
               checkOutput("done_missing", {31'd0, done}, 32'd1);
               e = sb_q.pop_front();
               held_result = e.product;
            end
         end
         checkOutput("busy", {31'd0, busy}, {31'd0, exp_busy});
         checkOutput("stall", {31'd0, stall}, {31'd0, exp_busy});
         if (exp_busy) begin
            checkOutput("run_op", {28'd0, alu_operation}, 32'h2);
         end else begin
            checkOutput("pass_op", {28'd0, alu_operation}, {28'd0, cpu_operation});
            checkOutput("pass_x", alu_in_x, cpu_in_x);
            checkOutput("pass_y", alu_in_y, cpu_in_y);
         end
         checkOutput("result_hold", result, held_result);
      end
   end

   // Main stimulus sequence.
   initial begin
      int target;
      logic [31:0] ra;
      logic [31:0] rb;
      n_checks      = 0;
      n_pass        = 0;
      mon_en        = 1'b0;
      held_result   = 32'd0;
      reset         = 1'b1;
      start         = 1'b0;
      operand_a     = 32'd0;
      operand_b     = 32'd0;
      cpu_operation = 4'b0000;
      cpu_in_x      = 32'd0;
      cpu_in_y      = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1'b1;

      // Reset state and pipeline pass-through in IDLE.
      @(negedge clk);
      checkOutput("reset_result", result, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      tick();
      cpu_operation = 4'b0010;
      cpu_in_x      = 32'd2565;
      cpu_in_y      = 32'd1560;
      @(negedge clk);
      checkOutput("pass_sum", alu_out_s, 32'd4125);
      checkOutput("pass_stall", {31'd0, stall}, 32'd0);

      // Directed multiplies: small, full length, zero, early exit.
      tick();
      $display("[TB] directed multiplies");
      applyStimulus(32'd3, 32'd5);
      waitIdle();
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      waitIdle();
      applyStimulus(32'h1234_5678, 32'd0);
      waitIdle();
      applyStimulus(32'd2565, 32'd1560);
      waitIdle();

      // Start ignored mid-RUN, then back-to-back start held in DONE.
      $display("[TB] ignored start and back-to-back");
      applyStimulus(32'd1000, 32'h80);
      target = sb_q[$].done_cycle;
      applyStimulus(32'd9, 32'd9);
      while (cyc < target) tick();
      applyStimulus(32'd7, 32'd6);
      waitIdle();

      // Reset in the third RUN cycle of a long multiply.
      $display("[TB] reset mid-operation");
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tick();
      tick();
      reset = 1'b1;
      tick();
      sb_q.delete();
      held_result = 32'd0;
      reset       = 1'b0;
      @(negedge clk);
      checkOutput("reset_abort_result", result, 32'd0);
      checkOutput("reset_abort_busy", {31'd0, busy}, 32'd0);
      repeat (35) tick();

      // Random operands with random spacing, including overlapping starts.
      $display("[TB] random multiplies");
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         applyStimulus(ra, rb);
         repeat ($urandom_range(0, 34)) tick();
      end
      waitIdle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
